regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regarb_pkg.sv | 15 +
 rtl/rr_arb2.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regarb_pkg.sv
// Shared widths, counts and dump FSM encodings for the register-file write arbiter.
package regarb_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned CNT_W      = 16;

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_SCAN = 2'd1,
      D_DONE = 2'd2
   } dump_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with a one-bit pointer that moves only on a transfer.
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic hold,
   output logic gnt_a,
   output logic gnt_b
);

   logic prio_b;

   // Grants are combinational; a grant always coincides with a transfer.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!rst && !hold) begin
         if (req_a && (!req_b || !prio_b)) begin
            gnt_a = 1'b1;
         end else if (req_b) begin
            gnt_b = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_b <= 1'b0;
      end else if (gnt_a) begin
         prio_b <= 1'b1;
      end else if (gnt_b) begin
         prio_b <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates execute/load writebacks onto one register-file write port.
// Define REGARB_DUMP_EN to build the register snapshot (dump) FSM.
import regarb_pkg::*;

module regfile_write_arbiter #(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              rf_rw,
   output logic [ADDR_W-1:0] rf_addr3,
   output logic [DATA_W-1:0] rf_data3,
   input  logic              dump_start,
   output logic [ADDR_W-1:0] dump_addr,
   input  logic [DATA_W-1:0] dump_rdata,
   output logic              dump_valid,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_done,
   output logic [CNT_W-1:0]  conflict_cnt
);

   logic stall;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_a (a_valid),
      .req_b (b_valid),
      .hold  (stall),
      .gnt_a (a_ready),
      .gnt_b (b_ready)
   );

   // Write port register; register 0 is read-only so its writes are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_rw    <= 1'b0;
         rf_addr3 <= '0;
         rf_data3 <= '0;
      end else begin
         rf_rw <= 1'b0;
         if (a_ready && (a_addr != '0)) begin
            rf_rw    <= 1'b1;
            rf_addr3 <= a_addr;
            rf_data3 <= a_data;
         end else if (b_ready && (b_addr != '0)) begin
            rf_rw    <= 1'b1;
            rf_addr3 <= b_addr;
            rf_data3 <= b_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (a_valid && b_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
         conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

`ifdef REGARB_DUMP_EN
   dump_state_t dstate;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dstate     <= D_IDLE;
         dump_valid <= 1'b0;
         dump_done  <= 1'b0;
         dump_addr  <= '0;
      end else begin
         case (dstate)
            D_IDLE: begin
               dump_addr <= '0;
               dump_done <= 1'b0;
               if (dump_start) begin
                  dstate     <= D_SCAN;
                  dump_valid <= 1'b1;
               end
            end
            D_SCAN: begin
               if (dump_addr == ADDR_W'(NUM_REGS - 1)) begin
                  dstate     <= D_DONE;
                  dump_valid <= 1'b0;
                  dump_done  <= 1'b1;
               end else begin
                  dump_addr <= dump_addr + ADDR_W'(1);
               end
            end
            D_DONE: begin
               dstate    <= D_IDLE;
               dump_done <= 1'b0;
               dump_addr <= '0;
            end
            default: begin
               dstate     <= D_IDLE;
               dump_valid <= 1'b0;
               dump_done  <= 1'b0;
               dump_addr  <= '0;
            end
         endcase
      end
   end

   // Read data is gated straight through so each word lines up with dump_addr.
   assign dump_data = dump_valid ? dump_rdata : '0;
   assign stall     = (dstate != D_IDLE);
`else
   logic unused_dump;

   assign dump_addr   = '0;
   assign dump_valid  = 1'b0;
   assign dump_done   = 1'b0;
   assign dump_data   = '0;
   assign stall       = 1'b0;
   assign unused_dump = dump_start ^ (^dump_rdata);
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter; dump checks follow REGARB_DUMP_EN.
module tb_regfile_write_arbiter;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } word_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, b_valid, a_ready, b_ready;
   logic [4:0]  a_addr, b_addr, rf_addr3, dump_addr;
   logic [31:0] a_data, b_data, rf_data3, dump_rdata, dump_data;
   logic        rf_rw, dump_start, dump_valid, dump_done;
   logic [15:0] conflict_cnt;

   logic [31:0] regs [32];
   word_t       wr_q[$];
   word_t       dq[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;

   regfile_write_arbiter dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .rf_rw(rf_rw), .rf_addr3(rf_addr3), .rf_data3(rf_data3),
      .dump_start(dump_start), .dump_addr(dump_addr), .dump_rdata(dump_rdata),
      .dump_valid(dump_valid), .dump_data(dump_data), .dump_done(dump_done),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   assign dump_rdata = regs[dump_addr];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops expected writes and dump words whenever the DUT presents one.
   always @(negedge clk) begin
      if (!rst) begin
         chk("one_grant", 64'(a_ready && b_ready), 64'd0);
         if (rf_rw) begin
            n_checks++;
            if (wr_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", rf_addr3, rf_data3);
            end else begin
               word_t e;
               e = wr_q.pop_front();
               chk("rf_addr3", 64'(rf_addr3), 64'(e.addr));
               chk("rf_data3", 64'(rf_data3), 64'(e.data));
            end
         end
         if (dump_valid) begin
            n_checks++;
            if (dq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_dump: got addr 0x%0h, none expected", dump_addr);
            end else begin
               word_t e;
               e = dq.pop_front();
               chk("dump_addr", 64'(dump_addr), 64'(e.addr));
               chk("dump_data", 64'(dump_data), 64'(e.data));
            end
         end
         if (dump_done) done_cnt++;
      end
   end

   task automatic idle_inputs();
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      dump_start = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      wr_q.delete();
      dq.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One cycle of stimulus, entered and left at posedge+1; ea/eb are the expected grants.
   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                        input logic ea, input logic eb);
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      @(negedge clk);
      chk("a_ready", 64'(a_ready), 64'(ea));
      chk("b_ready", 64'(b_ready), 64'(eb));
      if (ea && aa != 5'd0) wr_q.push_back({aa, ad});
      if (eb && ba != 5'd0) wr_q.push_back({ba, bd});
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
      regs[9]  = 32'h18;
      regs[10] = 32'h8;

      // Reset state with both requesters active
      idle_inputs();
      rst = 1'b1;
      a_valid = 1'b1; a_addr = 5'd8; b_valid = 1'b1; b_addr = 5'd10;
      repeat (2) @(negedge clk);
      chk("rst_a_ready", 64'(a_ready), 64'd0);
      chk("rst_b_ready", 64'(b_ready), 64'd0);
      chk("rst_rf_rw", 64'(rf_rw), 64'd0);
      chk("rst_rf_addr3", 64'(rf_addr3), 64'd0);
      chk("rst_rf_data3", 64'(rf_data3), 64'd0);
      chk("rst_conflict", 64'(conflict_cnt), 64'd0);
      chk("rst_dump_valid", 64'(dump_valid), 64'd0);
      chk("rst_dump_addr", 64'(dump_addr), 64'd0);
      chk("rst_dump_done", 64'(dump_done), 64'd0);
      chk("rst_dump_data", 64'(dump_data), 64'd0);
      @(posedge clk);
      #1 idle_inputs();
      rst = 1'b0;

      // A only, then hold check
      drive(1'b1, 5'd9, 32'h18, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      chk("hold_rf_rw", 64'(rf_rw), 64'd0);
      chk("hold_rf_addr3", 64'(rf_addr3), 64'd9);
      chk("hold_rf_data3", 64'(rf_data3), 64'h18);
      @(posedge clk); #1;

      // Both valid from reset: A, B, A, B, then A again (B was last)
      do_reset();
      drive(1'b1, 5'd8, 32'h11, 1'b1, 5'd10, 32'h22, 1'b1, 1'b0);
      drive(1'b1, 5'd8, 32'h12, 1'b1, 5'd10, 32'h23, 1'b0, 1'b1);
      drive(1'b1, 5'd8, 32'h13, 1'b1, 5'd10, 32'h24, 1'b1, 1'b0);
      drive(1'b1, 5'd8, 32'h14, 1'b1, 5'd10, 32'h25, 1'b0, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      chk("conflict_4", 64'(conflict_cnt), 64'd4);
      drive(1'b1, 5'd3, 32'h31, 1'b1, 5'd4, 32'h41, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h42, 1'b0, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      chk("conflict_5", 64'(conflict_cnt), 64'd5);

      // Write to register 0 is consumed but produces no write
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF, 1'b0, 1'b1);
      @(negedge clk);
      chk("zero_rf_rw", 64'(rf_rw), 64'd0);
      @(posedge clk); #1;

      // Reset in the middle of a write; pointer must return to favouring A
      drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      chk("mid_rf_rw_pre", 64'(rf_rw), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rf_rw", 64'(rf_rw), 64'd0);
      chk("mid_rf_addr3", 64'(rf_addr3), 64'd0);
      chk("mid_a_ready", 64'(a_ready), 64'd0);
      do_reset();
      drive(1'b1, 5'd8, 32'h55, 1'b1, 5'd10, 32'h66, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

`ifdef REGARB_DUMP_EN
      // Full dump with A held high throughout the scan
      for (int i = 0; i < 32; i++) dq.push_back({5'(i), regs[i]});
      done_cnt = 0;
      dump_start = 1'b1;
      @(posedge clk); #1;
      dump_start = 1'b0;
      a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC0DE;
      for (int k = 1; k <= 33; k++) begin
         dump_start = (k == 5);
         @(negedge clk);
         chk("dump_a_ready", 64'(a_ready), 64'd0);
         if (k == 32) chk("dump_done_early", 64'(dump_done), 64'd0);
         if (k == 33) chk("dump_done", 64'(dump_done), 64'd1);
         @(posedge clk); #1;
      end
      drive(1'b1, 5'd12, 32'hC0DE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      chk("dump_words_left", 64'(dq.size()), 64'd0);
      chk("dump_done_cnt", 64'(done_cnt), 64'd1);
      chk("idle_dump_addr", 64'(dump_addr), 64'd0);

      // Reset on dump word 15
      for (int i = 0; i < 32; i++) dq.push_back({5'(i), regs[i]});
      dump_start = 1'b1;
      @(posedge clk); #1;
      dump_start = 1'b0;
      begin
         bit seen;
         seen = 1'b0;
         for (int k = 0; k < 40 && !seen; k++) begin
            if (dump_valid && dump_addr == 5'd15) seen = 1'b1;
            else begin
               @(posedge clk); #1;
            end
         end
         chk("dump_word15_reached", 64'(seen), 64'd1);
      end
      rst = 1'b1;
      #1;
      chk("rst15_dump_valid", 64'(dump_valid), 64'd0);
      chk("rst15_dump_addr", 64'(dump_addr), 64'd0);
      chk("rst15_rf_rw", 64'(rf_rw), 64'd0);
      do_reset();
      drive(1'b1, 5'd8, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      drive(1'b1, 5'd8, 32'h9A, 1'b1, 5'd10, 32'hAA, 1'b0, 1'b1);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
`else
      // Dump logic absent: start is ignored and arbitration never stalls
      dump_start = 1'b1;
      drive(1'b1, 5'd12, 32'hC0DE, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      dump_start = 1'b0;
      drive(1'b1, 5'd13, 32'hBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      chk("nodump_valid", 64'(dump_valid), 64'd0);
      chk("nodump_done", 64'(dump_done), 64'd0);
      chk("nodump_addr", 64'(dump_addr), 64'd0);
      chk("nodump_data", 64'(dump_data), 64'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
`endif

      // Counter saturation after 65540 conflict cycles (register-0 traffic only)
      do_reset();
      a_valid = 1'b1; b_valid = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      chk("conflict_65535", 64'(conflict_cnt), 64'hFFFF);
      repeat (5) @(posedge clk);
      #1;
      chk("conflict_sat", 64'(conflict_cnt), 64'hFFFF);
      idle_inputs();
      @(posedge clk); #1;

      chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
